// File: rtl/axi4l_reg_slice_if.sv
// AXI4-Lite channel types and the bus interface shared by both sides of the slice.
// aclk/aresetn are carried for completeness; this block clocks and resets from its own ports.
package axi4l_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;
  typedef logic [2:0]  prot_t;

  typedef struct packed { addr_t addr; prot_t prot; } ax_t;
  typedef struct packed { data_t data; strb_t strb; } w_t;
  typedef struct packed { resp_t resp; }              b_t;
  typedef struct packed { data_t data; resp_t resp; } r_t;
endpackage

interface axi4l_if;
  import axi4l_pkg::*;

  logic  aclk;
  logic  aresetn;

  addr_t awaddr;  prot_t awprot;  logic awvalid;  logic awready;
  data_t wdata;   strb_t wstrb;   logic wvalid;   logic wready;
  resp_t bresp;                   logic bvalid;   logic bready;
  addr_t araddr;  prot_t arprot;  logic arvalid;  logic arready;
  data_t rdata;   resp_t rresp;   logic rvalid;   logic rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );
endinterface

// File: rtl/axi4l_reg_slice.sv
// AXI4-Lite register slice, one skid buffer (or wire) per channel; 1 cycle latency per registered channel.
// Source ready is a flop (= skid empty), so sink backpressure never reaches the source combinationally.
module axi4l_skid #(
  parameter int W   = 1,
  parameter bit REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_e;

  generate
    if (REG) begin : g_reg
      state_e         state_q, state_d;
      logic           rdy_q;
      logic [W-1:0]   out_q, skid_q;
      logic           in_fire, out_fire;
      logic           load_out, load_skid, skid_to_out;

      assign in_rdy   = rdy_q;
      assign out_vld  = (state_q != EMPTY);
      assign out_dat  = out_q;
      assign in_fire  = in_vld & rdy_q;
      assign out_fire = out_vld & out_rdy;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= EMPTY;
          rdy_q   <= 1'b0;
          out_q   <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          rdy_q   <= (state_d != FULL);
          if (load_out)         out_q <= in_dat;
          else if (skid_to_out) out_q <= skid_q;
          if (load_skid)        skid_q <= in_dat;
        end
      end

      always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
          EMPTY: if (in_fire) begin
            state_d  = HALF;
            load_out = 1'b1;
          end
          HALF: begin
            if (in_fire && out_fire) begin
              load_out = 1'b1;
            end else if (in_fire) begin
              state_d   = FULL;
              load_skid = 1'b1;
            end else if (out_fire) begin
              state_d = EMPTY;
            end
          end
          FULL: if (out_fire) begin
            state_d     = HALF;
            skid_to_out = 1'b1;
          end
          default: state_d = EMPTY;
        endcase
      end
    end else begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_vld = in_vld;
      assign in_rdy  = out_rdy;
      assign out_dat = in_dat;
    end
  endgenerate
endmodule

module axi4l_reg_slice
  import axi4l_pkg::*;
#(
  parameter bit AW_REG = 1'b1,
  parameter bit W_REG  = 1'b1,
  parameter bit B_REG  = 1'b1,
  parameter bit AR_REG = 1'b1,
  parameter bit R_REG  = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  axi4l_if.slave  s_axi,
  axi4l_if.master m_axi
);
  ax_t aw_in, aw_out, ar_in, ar_out;
  w_t  w_in, w_out;
  b_t  b_in, b_out;
  r_t  r_in, r_out;

  logic unused_if_clk_rst;
  assign unused_if_clk_rst = ^{s_axi.aclk, s_axi.aresetn, m_axi.aclk, m_axi.aresetn};

  assign aw_in.addr = s_axi.awaddr;
  assign aw_in.prot = s_axi.awprot;
  assign m_axi.awaddr = aw_out.addr;
  assign m_axi.awprot = aw_out.prot;

  assign w_in.data = s_axi.wdata;
  assign w_in.strb = s_axi.wstrb;
  assign m_axi.wdata = w_out.data;
  assign m_axi.wstrb = w_out.strb;

  assign b_in.resp   = m_axi.bresp;
  assign s_axi.bresp = b_out.resp;

  assign ar_in.addr = s_axi.araddr;
  assign ar_in.prot = s_axi.arprot;
  assign m_axi.araddr = ar_out.addr;
  assign m_axi.arprot = ar_out.prot;

  assign r_in.data = m_axi.rdata;
  assign r_in.resp = m_axi.rresp;
  assign s_axi.rdata = r_out.data;
  assign s_axi.rresp = r_out.resp;

  // Forward channels: s_axi -> m_axi
  axi4l_skid #(.W($bits(ax_t)), .REG(AW_REG)) u_aw (
    .clk(clk), .rst(rst),
    .in_vld(s_axi.awvalid), .in_rdy(s_axi.awready), .in_dat(aw_in),
    .out_vld(m_axi.awvalid), .out_rdy(m_axi.awready), .out_dat(aw_out)
  );
  axi4l_skid #(.W($bits(w_t)), .REG(W_REG)) u_w (
    .clk(clk), .rst(rst),
    .in_vld(s_axi.wvalid), .in_rdy(s_axi.wready), .in_dat(w_in),
    .out_vld(m_axi.wvalid), .out_rdy(m_axi.wready), .out_dat(w_out)
  );
  axi4l_skid #(.W($bits(ax_t)), .REG(AR_REG)) u_ar (
    .clk(clk), .rst(rst),
    .in_vld(s_axi.arvalid), .in_rdy(s_axi.arready), .in_dat(ar_in),
    .out_vld(m_axi.arvalid), .out_rdy(m_axi.arready), .out_dat(ar_out)
  );

  // Reverse channels: m_axi -> s_axi
  axi4l_skid #(.W($bits(b_t)), .REG(B_REG)) u_b (
    .clk(clk), .rst(rst),
    .in_vld(m_axi.bvalid), .in_rdy(m_axi.bready), .in_dat(b_in),
    .out_vld(s_axi.bvalid), .out_rdy(s_axi.bready), .out_dat(b_out)
  );
  axi4l_skid #(.W($bits(r_t)), .REG(R_REG)) u_r (
    .clk(clk), .rst(rst),
    .in_vld(m_axi.rvalid), .in_rdy(m_axi.rready), .in_dat(r_in),
    .out_vld(s_axi.rvalid), .out_rdy(s_axi.rready), .out_dat(r_out)
  );
endmodule

// File: tb/tb_axi4l_reg_slice.sv
// Randomized bench for axi4l_reg_slice: every registered channel is modelled as a 2-entry queue
// whose source ready is "fewer than two beats held" and whose sink shows the oldest beat.
module tb_axi4l_reg_slice;
  logic clk;
  logic rst;

  axi4l_if s_axi ();
  axi4l_if m_axi ();
  axi4l_if pt_s ();
  axi4l_if pt_m ();

  axi4l_reg_slice u_dut (.clk(clk), .rst(rst), .s_axi(s_axi), .m_axi(m_axi));
  axi4l_reg_slice #(.AR_REG(1'b0)) u_pt (.clk(clk), .rst(rst), .s_axi(pt_s), .m_axi(pt_m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel index: 0=AW 1=W 2=B 3=AR 4=R
  string       nm [5] = '{"aw", "w", "b", "ar", "r"};
  bit          src_vld [5];
  bit          snk_rdy [5];
  bit          fired   [5];
  logic [63:0] src_dat [5];
  logic [63:0] msk     [5];
  logic        o_rdy   [5];
  logic        o_vld   [5];
  logic [63:0] o_dat   [5];
  logic [63:0] mq [5][$];

  int n_chk = 0;
  int n_err = 0;
  int ar_in_cnt, ar_out_cnt, ar_rdy_cnt;

  assign s_axi.aclk = clk;  assign s_axi.aresetn = ~rst;
  assign m_axi.aclk = clk;  assign m_axi.aresetn = ~rst;

  assign s_axi.awvalid = src_vld[0];
  assign {s_axi.awaddr, s_axi.awprot} = src_dat[0][34:0];
  assign m_axi.awready = snk_rdy[0];
  assign s_axi.wvalid = src_vld[1];
  assign {s_axi.wdata, s_axi.wstrb} = src_dat[1][35:0];
  assign m_axi.wready = snk_rdy[1];
  assign m_axi.bvalid = src_vld[2];
  assign m_axi.bresp = src_dat[2][1:0];
  assign s_axi.bready = snk_rdy[2];
  assign s_axi.arvalid = src_vld[3];
  assign {s_axi.araddr, s_axi.arprot} = src_dat[3][34:0];
  assign m_axi.arready = snk_rdy[3];
  assign m_axi.rvalid = src_vld[4];
  assign {m_axi.rdata, m_axi.rresp} = src_dat[4][33:0];
  assign s_axi.rready = snk_rdy[4];

  assign o_rdy[0] = s_axi.awready;  assign o_vld[0] = m_axi.awvalid;
  assign o_dat[0] = {29'd0, m_axi.awaddr, m_axi.awprot};
  assign o_rdy[1] = s_axi.wready;   assign o_vld[1] = m_axi.wvalid;
  assign o_dat[1] = {28'd0, m_axi.wdata, m_axi.wstrb};
  assign o_rdy[2] = m_axi.bready;   assign o_vld[2] = s_axi.bvalid;
  assign o_dat[2] = {62'd0, s_axi.bresp};
  assign o_rdy[3] = s_axi.arready;  assign o_vld[3] = m_axi.arvalid;
  assign o_dat[3] = {29'd0, m_axi.araddr, m_axi.arprot};
  assign o_rdy[4] = m_axi.rready;   assign o_vld[4] = s_axi.rvalid;
  assign o_dat[4] = {30'd0, s_axi.rdata, s_axi.rresp};

  // Pass-through instance: only AR is exercised, other channels held idle
  bit          pt_arv, pt_ardy;
  logic [31:0] pt_araddr;
  logic [2:0]  pt_arprot;
  assign pt_s.aclk = clk;  assign pt_s.aresetn = ~rst;
  assign pt_m.aclk = clk;  assign pt_m.aresetn = ~rst;
  assign pt_s.arvalid = pt_arv;
  assign pt_s.araddr  = pt_araddr;
  assign pt_s.arprot  = pt_arprot;
  assign pt_m.arready = pt_ardy;
  assign pt_s.awvalid = 1'b0;  assign pt_s.awaddr = '0;  assign pt_s.awprot = '0;
  assign pt_s.wvalid  = 1'b0;  assign pt_s.wdata  = '0;  assign pt_s.wstrb  = '0;
  assign pt_s.bready  = 1'b0;  assign pt_s.rready = 1'b0;
  assign pt_m.awready = 1'b0;  assign pt_m.wready = 1'b0;
  assign pt_m.bvalid  = 1'b0;  assign pt_m.bresp  = '0;
  assign pt_m.rvalid  = 1'b0;  assign pt_m.rdata  = '0;  assign pt_m.rresp = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("%s_src_rdy", nm[c]), 64'(o_rdy[c]), 64'(mq[c].size() < 2));
      chk($sformatf("%s_snk_vld", nm[c]), 64'(o_vld[c]), 64'(mq[c].size() > 0));
      if (mq[c].size() > 0)
        chk($sformatf("%s_snk_dat", nm[c]), o_dat[c], mq[c][0]);
    end
  endtask

  // Called just after a negedge with stimulus already applied; ends at the next negedge.
  task automatic cycle();
    bit inf [5];
    bit outf [5];
    for (int c = 0; c < 5; c++) begin
      inf[c]  = src_vld[c] && (mq[c].size() < 2);
      outf[c] = (mq[c].size() > 0) && snk_rdy[c];
    end
    if (s_axi.arvalid && s_axi.arready) ar_in_cnt++;
    if (m_axi.arvalid && m_axi.arready) ar_out_cnt++;
    if (s_axi.arready) ar_rdy_cnt++;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      if (outf[c]) void'(mq[c].pop_front());
      if (inf[c])  mq[c].push_back(src_dat[c]);
      fired[c] = inf[c];
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_all(input bit rdy);
    for (int c = 0; c < 5; c++) begin
      src_vld[c] = 1'b0;
      snk_rdy[c] = rdy;
    end
  endtask

  task automatic rand_run(input int n, input int vpct, input int rpct);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 5; c++) begin
        if (!src_vld[c] || fired[c]) begin
          src_vld[c] = (int'($urandom_range(0, 99)) < vpct);
          src_dat[c] = {$urandom, $urandom} & msk[c];
        end
        snk_rdy[c] = (int'($urandom_range(0, 99)) < rpct);
      end
      cycle();
    end
  endtask

  task automatic reset_values(input string pfx);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("%s_%s_src_rdy", pfx, nm[c]), 64'(o_rdy[c]), 64'd0);
      chk($sformatf("%s_%s_snk_vld", pfx, nm[c]), 64'(o_vld[c]), 64'd0);
    end
  endtask

  initial begin
    msk[0] = (64'd1 << 35) - 64'd1;
    msk[1] = (64'd1 << 36) - 64'd1;
    msk[2] = 64'd3;
    msk[3] = (64'd1 << 35) - 64'd1;
    msk[4] = (64'd1 << 34) - 64'd1;
    for (int c = 0; c < 5; c++) begin
      src_dat[c] = '0;
      fired[c]   = 1'b0;
    end
    idle_all(1'b0);
    pt_arv = 1'b0; pt_ardy = 1'b0; pt_araddr = '0; pt_arprot = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    reset_values("rst");
    chk("rst_awaddr", 64'(m_axi.awaddr), 64'd0);
    chk("rst_rdata", 64'(s_axi.rdata), 64'd0);
    rst = 1'b0;
    idle_all(1'b1);
    cycle();

    // Single write, then OKAY response one cycle after m_axi bvalid
    src_vld[0] = 1'b1; src_dat[0] = {29'd0, 32'h0000_0008, 3'd0};
    src_vld[1] = 1'b1; src_dat[1] = {28'd0, 32'hDEAD_BEEF, 4'hF};
    cycle();
    chk("wr_awvalid", 64'(m_axi.awvalid), 64'd1);
    chk("wr_awaddr", 64'(m_axi.awaddr), 64'h8);
    chk("wr_wvalid", 64'(m_axi.wvalid), 64'd1);
    chk("wr_wdata", 64'(m_axi.wdata), 64'hDEAD_BEEF);
    chk("wr_wstrb", 64'(m_axi.wstrb), 64'hF);
    src_vld[0] = 1'b0; src_vld[1] = 1'b0;
    src_vld[2] = 1'b1; src_dat[2] = 64'd0;
    cycle();
    chk("wr_bvalid", 64'(s_axi.bvalid), 64'd1);
    chk("wr_bresp", 64'(s_axi.bresp), 64'd0);
    src_vld[2] = 1'b0;
    repeat (2) cycle();

    // Streaming reads: 8 AR beats alternating 0x0/0x4, R data returned back-to-back
    ar_in_cnt = 0; ar_out_cnt = 0; ar_rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      src_vld[3] = 1'b1; src_dat[3] = {29'd0, 32'((i % 2) * 4), 3'd0};
      src_vld[4] = 1'b1; src_dat[4] = {30'd0, 32'hA000_0000 + 32'(i), 2'd0};
      cycle();
    end
    src_vld[3] = 1'b0; src_vld[4] = 1'b0;
    repeat (2) cycle();
    chk("ar_stream_in", 64'(ar_in_cnt), 64'd8);
    chk("ar_stream_out", 64'(ar_out_cnt), 64'd8);
    chk("ar_stream_rdy", 64'(ar_rdy_cnt), 64'd10);

    // Stall/skid on W: 0x1 held at output, 0x2 in skid, 0x3 waits
    snk_rdy[1] = 1'b0;
    src_vld[1] = 1'b1; src_dat[1] = {28'd0, 32'h1, 4'hF};
    cycle();
    src_dat[1] = {28'd0, 32'h2, 4'hF};
    cycle();
    src_dat[1] = {28'd0, 32'h3, 4'hF};
    repeat (2) cycle();
    chk("stall_wdata", 64'(m_axi.wdata), 64'h1);
    chk("stall_wready", 64'(s_axi.wready), 64'd0);
    snk_rdy[1] = 1'b1;
    cycle();
    chk("skid_wdata2", 64'(m_axi.wdata), 64'h2);
    chk("skid_wready_up", 64'(s_axi.wready), 64'd1);
    cycle();
    src_vld[1] = 1'b0;
    chk("skid_wdata3", 64'(m_axi.wdata), 64'h3);
    repeat (2) cycle();

    // Decoupled AW/W: W leads AW by 3 cycles
    src_vld[1] = 1'b1; src_dat[1] = {28'd0, 32'h55, 4'hF};
    cycle();
    src_vld[1] = 1'b0;
    chk("dec_wdata", 64'(m_axi.wdata), 64'h55);
    chk("dec_awvalid_early", 64'(m_axi.awvalid), 64'd0);
    repeat (2) cycle();
    src_vld[0] = 1'b1; src_dat[0] = {29'd0, 32'h0000_000C, 3'd0};
    cycle();
    src_vld[0] = 1'b0;
    chk("dec_awaddr", 64'(m_axi.awaddr), 64'hC);
    repeat (2) cycle();

    // Randomized traffic under several valid/ready densities
    rand_run(400, 100, 100);
    rand_run(600, 70, 50);
    rand_run(600, 90, 20);
    rand_run(400, 30, 90);

    // Reset mid-operation: AW full, B half
    idle_all(1'b0);
    repeat (3) cycle();
    for (int c = 0; c < 5; c++) snk_rdy[c] = 1'b1;
    repeat (3) cycle();
    idle_all(1'b0);
    src_vld[0] = 1'b1; src_dat[0] = {29'd0, 32'h10, 3'd1};
    src_vld[2] = 1'b1; src_dat[2] = 64'd2;
    cycle();
    src_dat[0] = {29'd0, 32'h14, 3'd2};
    src_vld[2] = 1'b0;
    cycle();
    src_vld[0] = 1'b0;
    chk("pre_rst_awready", 64'(s_axi.awready), 64'd0);
    chk("pre_rst_bvalid", 64'(s_axi.bvalid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    reset_values("midrst");
    for (int c = 0; c < 5; c++) begin
      mq[c].delete();
      fired[c] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_all(1'b1);
    cycle();
    chk("post_rst_awready", 64'(s_axi.awready), 64'd1);
    src_vld[0] = 1'b1; src_dat[0] = {29'd0, 32'h8, 3'd0};
    src_vld[1] = 1'b1; src_dat[1] = {28'd0, 32'h1234_5678, 4'h3};
    cycle();
    src_vld[0] = 1'b0; src_vld[1] = 1'b0;
    chk("post_rst_awaddr", 64'(m_axi.awaddr), 64'h8);
    chk("post_rst_wdata", 64'(m_axi.wdata), 64'h1234_5678);
    rand_run(300, 70, 60);

    // Pass-through AR on the second instance follows combinationally
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pt_arv    = ($urandom_range(0, 1) == 1);
      pt_ardy   = ($urandom_range(0, 1) == 1);
      pt_araddr = $urandom;
      pt_arprot = 3'($urandom_range(0, 7));
      #1;
      chk("pt_arvalid", 64'(pt_m.arvalid), 64'(pt_arv));
      chk("pt_araddr", 64'(pt_m.araddr), 64'(pt_araddr));
      chk("pt_arprot", 64'(pt_m.arprot), 64'(pt_arprot));
      chk("pt_arready", 64'(pt_s.arready), 64'(pt_ardy));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi4l_reg_slice.md
Name: axi4l_reg_slice

Overview:
- Full-throughput AXI4-Lite register slice on all five channels, placed between the interconnect master port and a slave such as the machine timer peripheral.
- Breaks every combinational valid/ready/payload path between master and slave so the slave's address decode and byte-strobe logic meets timing on the Arty A7-100 SoC.
- Each channel can be independently set to registered (skid buffer) or pass-through by parameter.
- Protocol-transparent: no reordering, no merging, no response generation.

Parameters:
- AW_REG, 1, 1 = AW channel registered, 0 = combinational pass-through
- W_REG, 1, same for W channel
- B_REG, 1, same for B channel
- AR_REG, 1, same for AR channel
- R_REG, 1, same for R channel

Ports:
- clk  input  1  single clock for all channels; the aclk fields of both interfaces are ignored.
- rst  input  1  asynchronous, active-high reset; the aresetn fields of both interfaces are ignored.
- s_axi  axi4l_if.slave  —  upstream side; widths taken from axi4l_pkg (addr_t, 32-bit data, strb_t, resp_t).
- m_axi  axi4l_if.master  —  downstream side, toward the peripheral.

Behaviour:
- Forward channels (AW, W, AR) run source s_axi to sink m_axi. Reverse channels (B, R) run source m_axi to sink s_axi.
- Each registered channel is one skid buffer:
  - Output register: out_valid plus payload.
  - Skid register: skid_valid plus payload.
  - Payload: AW/AR carry addr and prot; W carries data and strb; B carries resp; R carries data and resp.
  - Channel state is one of EMPTY (out_valid=0, skid_valid=0), HALF (out_valid=1, skid_valid=0), FULL (out_valid=1, skid_valid=1).
- Source-side ready is registered and equals !skid_valid.
  - It is never a combinational function of the sink-side ready.
- Transitions (in_fire = src valid & src ready; out_fire = out_valid & sink ready):
  - EMPTY, in_fire -> HALF. Payload loads the output register; valid appears at the sink exactly 1 cycle after in_fire.
  - HALF, in_fire & out_fire -> HALF. Output register reloads from the input.
  - HALF, in_fire & !out_fire -> FULL. Input is captured in the skid register; src ready drops the next cycle.
  - HALF, !in_fire & out_fire -> EMPTY.
  - FULL, out_fire -> HALF. Skid moves to the output register; src ready rises the next cycle.
  - FULL, no in_fire is possible because ready is 0.
  - All other combinations: hold.
- Throughput: 1 beat per cycle sustained when the sink ready is held 1. Latency is 1 cycle per registered channel.
- Ordering: strict FIFO per channel; the output register is always older than the skid register.
- Payload stability: the sink-side payload must not change while out_valid=1 and sink ready=0.
- Channel independence:
  - AW and W are buffered independently; no pairing is enforced.
  - An AW accepted N cycles before its W is delivered in the same relative order.
- Pass-through channel (xx_REG=0): valid, ready and payload are wired straight through with zero latency and hold no state.
- Reset (rst=1, asynchronous assert):
  - All out_valid and skid_valid clear to 0 immediately.
  - Source-side readies are forced to 1 from the first clock after reset deassertion; while rst=1 they are 0.
  - Payload registers clear to 0.
  - A transfer in flight at reset is dropped. Both neighbours share rst, so no half-completed handshake survives.
- Reset release is synchronous to clk: deassertion is taken through the SoC reset synchronizer, not inside this block.

Test Plan:
- Single write: s_axi AW addr=0x008 with W data=0xDEADBEEF, strb=0xF, m_axi awready/wready=1 -> m_axi awvalid/wvalid both assert 1 cycle later with identical payload. bresp OKAY returns to s_axi 1 cycle after m_axi bvalid.
- Streaming reads: 8 back-to-back AR beats at addr 0x000/0x004 alternating, m_axi arready=1, rready=1 -> 8 m_axi AR beats on 8 consecutive cycles; s_axi arready stays 1 throughout; R data order matches.
- Stall/skid: m_axi wready=0 while s_axi sends W data 0x1, 0x2, 0x3 ->
  - 0x1 is held at the m_axi output, 0x2 is in the skid register, and s_axi wready=0 from the cycle after 0x2 is accepted.
  - When wready=1, the m_axi side sees 0x1 then 0x2 on consecutive cycles, and 0x3 is accepted only after wready re-rises. No beat is lost or duplicated.
- Decoupled AW/W: W data=0x55 sent 3 cycles before AW addr=0x00C -> both are delivered unmodified, W first. The timer's mtimecmp[63:32] is updated to 0x55.
- Reset mid-operation: assert rst with AW in FULL state and B in HALF state ->
  - All m_axi and s_axi valids are 0 within the same cycle.
  - After release, s_axi awready=1 and the next write completes normally.
- Pass-through: AR_REG=0 -> m_axi arvalid/araddr follow s_axi in the same cycle, and s_axi arready equals m_axi arready combinationally.
